// File: rtl/xpar_mailbox_if.sv
// rtl/xpar_mailbox_if.sv - parallel-bus and host-stream bundle for xpar_mailbox
//
// Purpose: groups the picoVersat parallel register bus and the host
// valid/ready streams into one bundle.
// Signals:
//   par_addr/par_we/par_wdata  core -> mailbox register access
//   par_rdata                  mailbox -> core read data (combinational)
//   in_valid/in_data/in_ready  host -> RX FIFO stream
//   out_valid/out_data/out_ready TX FIFO -> host stream
// Modports: master = core + host side, slave = mailbox.
interface xpar_mailbox_if #(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 8
);
  logic [PAR_ADDR_W-1:0] par_addr;
  logic                  par_we;
  logic [DATA_W-1:0]     par_wdata;
  logic [DATA_W-1:0]     par_rdata;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;

  modport master (
    output par_addr, par_we, par_wdata, in_valid, in_data, out_ready,
    input  par_rdata, in_ready, out_valid, out_data
  );

  modport slave (
    input  par_addr, par_we, par_wdata, in_valid, in_data, out_ready,
    output par_rdata, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xpar_mailbox.sv
// rtl/xpar_mailbox.sv - two-FIFO mailbox between xtop parallel bus and host stream
//
// Purpose: host words are queued in RX, read and popped by the core through
// the register map; core words are pushed into TX and drained by the host.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  xpar_mailbox_if.slave (register bus + host RX/TX streams)
// Register map (full par_addr decode):
//   0 RXDATA  rd: RX head (0 if empty)   wr: pop RX
//   1 STATUS  rd: {tx_cnt[23:16], rx_cnt[15:8], udf, ovf, tx_full, tx_empty, rx_full, rx_empty}
//   2 TXDATA  wr: push TX                 rd: 0
//   3 CLEAR   wr: bit0 clears tx_overflow, bit1 clears rx_underflow
module xpar_mailbox #(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 8,
  parameter int DEPTH      = 16
) (
  input logic           clk,
  input logic           rst,
  xpar_mailbox_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PAR_ADDR_W-1:0] A_RXDATA = PAR_ADDR_W'(0);
  localparam logic [PAR_ADDR_W-1:0] A_STATUS = PAR_ADDR_W'(1);
  localparam logic [PAR_ADDR_W-1:0] A_TXDATA = PAR_ADDR_W'(2);
  localparam logic [PAR_ADDR_W-1:0] A_CLEAR  = PAR_ADDR_W'(3);

  logic [DATA_W-1:0] r_rx_mem [DEPTH];
  logic [DATA_W-1:0] r_tx_mem [DEPTH];
  logic [PTR_W-1:0]  r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [CNT_W-1:0]  r_rx_cnt, r_tx_cnt;
  logic              r_tx_ovf, r_rx_udf;

  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic w_rx_pop_req, w_tx_push_req, w_clr_wr;
  logic w_ovf_set, w_udf_set, w_ovf_clr, w_udf_clr;
  logic [31:0]       w_status;
  logic [DATA_W-1:0] w_rdata;

  // Full/empty come only from registered counts: no same-cycle pass-through.
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CNT_W'(DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == CNT_W'(DEPTH));

  assign w_rx_pop_req  = bus.par_we && (bus.par_addr == A_RXDATA);
  assign w_tx_push_req = bus.par_we && (bus.par_addr == A_TXDATA);
  assign w_clr_wr      = bus.par_we && (bus.par_addr == A_CLEAR);

  assign w_rx_push = bus.in_valid && !w_rx_full;
  assign w_rx_pop  = w_rx_pop_req && !w_rx_empty;
  assign w_tx_push = w_tx_push_req && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && bus.out_ready;

  assign w_ovf_set = w_tx_push_req && w_tx_full;
  assign w_udf_set = w_rx_pop_req && w_rx_empty;
  assign w_ovf_clr = w_clr_wr && bus.par_wdata[0];
  assign w_udf_clr = w_clr_wr && bus.par_wdata[1];

  // Storage arrays carry no reset; empty-gating on the read side keeps
  // stale contents invisible after reset.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.in_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.par_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_cnt  <= '0;
      r_tx_cnt  <= '0;
      r_tx_ovf  <= 1'b0;
      r_rx_udf  <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_W'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_W'(1);
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_W'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_W'(1);

      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_W'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_W'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      // Set has priority over clear.
      r_tx_ovf <= w_ovf_set || (r_tx_ovf && !w_ovf_clr);
      r_rx_udf <= w_udf_set || (r_rx_udf && !w_udf_clr);
    end
  end

  assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), 2'b00,
                     r_rx_udf, r_tx_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

  // Zero-latency read: xtop samples par_in in the access cycle.
  always_comb begin
    w_rdata = '0;
    if (bus.par_addr == A_RXDATA)
      w_rdata = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    else if (bus.par_addr == A_STATUS)
      w_rdata = DATA_W'(w_status);
  end

  assign bus.par_rdata = w_rdata;
  assign bus.in_ready  = !w_rx_full;
  assign bus.out_valid = !w_tx_empty;
  assign bus.out_data  = w_tx_empty ? '0 : r_tx_mem[r_tx_rptr];
endmodule

// File: tb/tb_xpar_mailbox.sv
// tb/tb_xpar_mailbox.sv - directed self-checking bench for xpar_mailbox
module tb_xpar_mailbox;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  xpar_mailbox_if #(.DATA_W(32), .PAR_ADDR_W(8)) bus ();

  xpar_mailbox #(.DATA_W(32), .PAR_ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.par_addr = a;
    bus.par_we   = 1'b0;
    #1;
    d = bus.par_rdata;
  endtask

  task automatic core_wr(input logic [7:0] a, input logic [31:0] d);
    bus.par_addr  = a;
    bus.par_wdata = d;
    bus.par_we    = 1'b1;
    step();
    bus.par_we    = 1'b0;
  endtask

  task automatic host_push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] q[$];
  int sent, recv, cyc;
  bit  pop, push, exp_rdy;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.par_addr  = '0;
    bus.par_we    = 1'b0;
    bus.par_wdata = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b0;
    rst = 1'b0;

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", bus.out_data, 32'd0);
    check_val("rst_rdata_a0", bus.par_rdata, 32'd0);
    rd(8'd1, v);
    check_val("rst_status", v, 32'h0000_0005);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rd(8'd1, v);
    check_val("post_rst_status", v, 32'h0000_0005);

    // RX path
    host_push(32'hA1);
    host_push(32'hB2);
    host_push(32'hC3);
    rd(8'd1, v);
    check_val("rx3_status", v, 32'h0000_0304);
    rd(8'd0, v);
    check_val("rx_head_a1", v, 32'hA1);
    core_wr(8'd0, 32'h0);
    rd(8'd0, v);
    check_val("rx_head_b2", v, 32'hB2);
    core_wr(8'd0, 32'h0);
    core_wr(8'd0, 32'h0);
    rd(8'd1, v);
    check_val("rx_drained_status", v, 32'h0000_0005);
    core_wr(8'd0, 32'h0);
    rd(8'd1, v);
    check_val("rx_underflow_status", v, 32'h0000_0025);
    rd(8'd2, v);
    check_val("txdata_read_zero", v, 32'h0);
    core_wr(8'd3, 32'h2);
    rd(8'd1, v);
    check_val("udf_cleared", v, 32'h0000_0005);

    // RX full
    for (int i = 0; i < DEPTH; i++) host_push(32'(i));
    check_val("rxfull_in_ready", 32'(bus.in_ready), 32'd0);
    rd(8'd1, v);
    check_val("rxfull_status", v, 32'h0000_1006);
    host_push(32'h99);
    rd(8'd1, v);
    check_val("rxfull_extra_refused", v, 32'h0000_1006);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h77;
    bus.par_addr  = 8'd0;
    bus.par_we    = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.par_we    = 1'b0;
    rd(8'd1, v);
    check_val("rxfull_poppush_status", v, 32'h0000_0F04);
    for (int i = 1; i < DEPTH; i++) begin
      rd(8'd0, v);
      check_val($sformatf("rxfull_drain_%0d", i), v, 32'(i));
      core_wr(8'd0, 32'h0);
    end
    rd(8'd1, v);
    check_val("rxfull_drained", v, 32'h0000_0005);

    // TX path
    core_wr(8'd2, 32'h11);
    core_wr(8'd2, 32'h22);
    check_val("tx_out_valid", 32'(bus.out_valid), 32'd1);
    check_val("tx_head_11", bus.out_data, 32'h11);
    step();
    step();
    check_val("tx_head_11_stable", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    #1;
    check_val("tx_drain_11", bus.out_data, 32'h11);
    step();
    check_val("tx_drain_22", bus.out_data, 32'h22);
    step();
    check_val("tx_drained_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // TX overflow and clear
    for (int i = 0; i <= DEPTH; i++) core_wr(8'd2, 32'h100 + 32'(i));
    rd(8'd1, v);
    check_val("txovf_status", v, 32'h0010_0019);
    core_wr(8'd3, 32'h1);
    rd(8'd1, v);
    check_val("txovf_cleared", v, 32'h0010_0009);
    core_wr(8'd3, 32'h1);
    core_wr(8'd2, 32'h999);
    rd(8'd1, v);
    check_val("txovf_reset_after_clear", v, 32'h0010_0019);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #0;
      check_val($sformatf("txovf_drain_%0d", i), bus.out_data, 32'h100 + 32'(i));
      step();
    end
    check_val("txovf_last_absent", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    core_wr(8'd3, 32'h1);

    // Reset in mid-traffic discards everything
    host_push(32'h55);
    host_push(32'h66);
    core_wr(8'd2, 32'h77);
    bus.par_addr = 8'd1;
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_status", bus.par_rdata, 32'h0000_0005);
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_out_data", bus.out_data, 32'd0);
    step();
    rst = 1'b1;
    step();
    rd(8'd0, v);
    check_val("midrst_rx_head", v, 32'd0);

    // RX wrap-around with concurrent traffic
    q.delete();
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 3 * DEPTH && cyc < 2000) begin
      exp_rdy = (q.size() < DEPTH);
      push = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      pop  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.in_valid = push;
      bus.in_data  = 32'h5000 + 32'(sent);
      bus.par_addr = 8'd0;
      bus.par_we   = pop;
      #1;
      check_val("rxw_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check_val("rxw_head", bus.par_rdata, (q.size() > 0) ? q[0] : 32'd0);
      @(posedge clk);
      if (pop) begin
        void'(q.pop_front());
        recv++;
      end
      if (push && exp_rdy) begin
        q.push_back(32'h5000 + 32'(sent));
        sent++;
      end
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.par_we   = 1'b0;
    check_val("rxw_all_received", 32'(recv), 32'(3 * DEPTH));

    // TX wrap-around with concurrent traffic
    q.delete();
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 3 * DEPTH && cyc < 2000) begin
      push = (sent < 3 * DEPTH) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      pop  = ($urandom_range(0, 2) != 0);
      bus.par_addr  = 8'd2;
      bus.par_wdata = 32'h7000 + 32'(sent);
      bus.par_we    = push;
      bus.out_ready = pop;
      #1;
      check_val("txw_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check_val("txw_head", bus.out_data, q[0]);
      @(posedge clk);
      if (pop && q.size() > 0) begin
        void'(q.pop_front());
        recv++;
      end
      if (push) begin
        q.push_back(32'h7000 + 32'(sent));
        sent++;
      end
      #1;
      cyc++;
    end
    bus.par_we    = 1'b0;
    bus.out_ready = 1'b0;
    check_val("txw_all_received", 32'(recv), 32'(3 * DEPTH));
    rd(8'd1, v);
    check_val("final_status", v, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
